alu_seq: RTL

- Micro-sequencer in front of the 4-bit ALU (ADD when sel=0, bitwise NAND when sel=1, combinational, no carry out).
- Accepts one opcode plus operands per request over a valid/ready handshake.
- Builds 8 operations from 1 to 4 ALU passes, one pass per clock, keeping intermediates in two temp registers.
- Returns a 4-bit result over a second valid/ready handshake. Sits between the CPU decode stage and the shared ALU instance.

---
 rtl/alu_seq_pkg.sv | 61 ++++++
 rtl/alu_seq_ucode.sv | 68 ++++++
 rtl/alu_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU micro-sequencer.
// Holds the opcodes, FSM states, microcode source/destination encodings and the ROM-entry helper.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_INC  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  localparam logic ALU_SEL_ADD  = 1'b0;
  localparam logic ALU_SEL_NAND = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SRC_A   = 3'd0,
    SRC_B   = 3'd1,
    SRC_T0  = 3'd2,
    SRC_T1  = 3'd3,
    SRC_ONE = 3'd4
  } src_t;

  typedef enum logic [1:0] {
    DST_T0  = 2'd0,
    DST_T1  = 2'd1,
    DST_RES = 2'd2
  } dst_t;

  typedef struct packed {
    src_t src_a;
    src_t src_b;
    logic sel;
    dst_t dst;
    logic last;
  } ucode_t;

  function automatic ucode_t uc(
    input src_t a,
    input src_t b,
    input logic s,
    input dst_t d,
    input logic l
  );
    ucode_t u;
    u.src_a = a;
    u.src_b = b;
    u.sel   = s;
    u.dst   = d;
    u.last  = l;
    return u;
  endfunction

endpackage

// File: rtl/alu_seq_ucode.sv
// alu_seq_ucode: combinational microcode ROM indexed by (op, pass).
// Ports: op, pass in; src_a, src_b, sel, dst, last out.
module alu_seq_ucode
  import alu_seq_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] op,
  input  logic [1:0]     pass,
  output src_t           src_a,
  output src_t           src_b,
  output logic           sel,
  output dst_t           dst,
  output logic           last
);

  localparam logic N = ALU_SEL_NAND;
  localparam logic P = ALU_SEL_ADD;

  ucode_t u;

  // Unused (op, pass) pairs fall back to a terminating ADD into RES.
  always_comb begin
    u = uc(SRC_A, SRC_B, P, DST_RES, 1'b1);
    unique case ({op, pass})
      {OP_ADD, 2'd0}:
        u = uc(SRC_A, SRC_B, P, DST_RES, 1'b1);
      {OP_NAND, 2'd0}:
        u = uc(SRC_A, SRC_B, N, DST_RES, 1'b1);
      {OP_NOT, 2'd0}:
        u = uc(SRC_A, SRC_A, N, DST_RES, 1'b1);
      {OP_AND, 2'd0}:
        u = uc(SRC_A, SRC_B, N, DST_T0, 1'b0);
      {OP_AND, 2'd1}:
        u = uc(SRC_T0, SRC_T0, N, DST_RES, 1'b1);
      {OP_OR, 2'd0}:
        u = uc(SRC_A, SRC_A, N, DST_T0, 1'b0);
      {OP_OR, 2'd1}:
        u = uc(SRC_B, SRC_B, N, DST_T1, 1'b0);
      {OP_OR, 2'd2}:
        u = uc(SRC_T0, SRC_T1, N, DST_RES, 1'b1);
      {OP_SUB, 2'd0}:
        u = uc(SRC_B, SRC_B, N, DST_T0, 1'b0);
      {OP_SUB, 2'd1}:
        u = uc(SRC_A, SRC_T0, P, DST_T0, 1'b0);
      {OP_SUB, 2'd2}:
        u = uc(SRC_T0, SRC_ONE, P, DST_RES, 1'b1);
      {OP_INC, 2'd0}:
        u = uc(SRC_A, SRC_ONE, P, DST_RES, 1'b1);
      {OP_XOR, 2'd0}:
        u = uc(SRC_A, SRC_B, N, DST_T0, 1'b0);
      {OP_XOR, 2'd1}:
        u = uc(SRC_A, SRC_T0, N, DST_T1, 1'b0);
      {OP_XOR, 2'd2}:
        u = uc(SRC_B, SRC_T0, N, DST_T0, 1'b0);
      {OP_XOR, 2'd3}:
        u = uc(SRC_T1, SRC_T0, N, DST_RES, 1'b1);
      default: ;
    endcase
  end

  assign src_a = u.src_a;
  assign src_b = u.src_b;
  assign sel   = u.sel;
  assign dst   = u.dst;
  assign last  = u.last;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: micro-sequencer building 8 ops from 1-4 passes of an external 4-bit ADD/NAND ALU.
// Ports: req_* in (valid/ready), resp_* out (valid/ready), alu_* to/from ALU; resp_zero with ALU_SEQ_ZERO_FLAG_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W   = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [OPW-1:0] req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [W-1:0]   resp_res,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_sel,
  input  logic [W-1:0]   alu_res
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic           resp_zero
`endif
);

  state_t         state;
  logic [OPW-1:0] op;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [W-1:0]   t0;
  logic [W-1:0]   t1;
  logic [1:0]     pass;

  src_t u_src_a;
  src_t u_src_b;
  logic u_sel;
  dst_t u_dst;
  logic u_last;

  alu_seq_ucode #(
    .OPW (OPW)
  ) u_ucode (
    .op    (op),
    .pass  (pass),
    .src_a (u_src_a),
    .src_b (u_src_b),
    .sel   (u_sel),
    .dst   (u_dst),
    .last  (u_last)
  );

  function automatic logic [W-1:0] pick(
    input src_t         s,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] x0,
    input logic [W-1:0] x1
  );
    logic [W-1:0] v;
    v = '0;
    unique case (s)
      SRC_A:   v = a;
      SRC_B:   v = b;
      SRC_T0:  v = x0;
      SRC_T1:  v = x1;
      SRC_ONE: v = W'(1);
      default: v = '0;
    endcase
    return v;
  endfunction

  // ALU drive is parked at zero outside EXEC, so reset clears it
  // asynchronously through the state register.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = ALU_SEL_ADD;
    if (state == EXEC) begin
      alu_a   = pick(u_src_a, opa, opb, t0, t1);
      alu_b   = pick(u_src_b, opa, opb, t0, t1);
      alu_sel = u_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_res   <= '0;
      op         <= '0;
      opa        <= '0;
      opb        <= '0;
      t0         <= '0;
      t1         <= '0;
      pass       <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      resp_zero  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op        <= req_op;
            opa       <= req_a;
            opb       <= req_b;
            pass      <= '0;
            state     <= EXEC;
            req_ready <= 1'b0;
          end
        end
        EXEC: begin
          unique case (u_dst)
            DST_T0: t0 <= alu_res;
            DST_T1: t1 <= alu_res;
            DST_RES: begin
              resp_res  <= alu_res;
`ifdef ALU_SEQ_ZERO_FLAG_EN
              resp_zero <= (alu_res == '0);
`endif
            end
            default: ;
          endcase
          pass <= pass + 2'd1;
          if (u_last) begin
            state      <= DONE;
            resp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
